// File: rtl/hash160_pkg.sv
// hash160_pkg: shared types and constants for the Hash160 transmit framer
package hash160_pkg;
  localparam int BLOCK_W = 512;
  localparam int DIGEST_W = 160;
  localparam int NUM_BYTES = 64;
  localparam int BCNT_W = 6;
  localparam logic [7:0] START_BYTE = 8'hAA;
  typedef enum logic [2:0] {S_IDLE, S_CRST, S_GAP, S_HDR, S_DATA, S_WAIT} state_e;
endpackage

// File: rtl/hash160_block_shreg.sv
// hash160_block_shreg: 512-bit block register, loads whole and shifts out MSB byte first
module hash160_block_shreg
  import hash160_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic [7:0]         msb_o
);
  logic [BLOCK_W-1:0] sh_q;
  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else if (load_i) sh_q <= data_i;
    else if (shift_i) sh_q <= {sh_q[BLOCK_W-9:0], 8'h00};
  end
  assign msb_o = sh_q[BLOCK_W-1 -: 8];
endmodule

// File: rtl/hash160_frame_tx.sv
// hash160_frame_tx: frames one 512-bit block onto the core's byte stream and captures its digest
module hash160_frame_tx
  import hash160_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [BLOCK_W-1:0]  i_block,
  output logic                o_ready,
  output logic                o_core_rst_n,
  output logic [7:0]          o_text,
  input  logic                i_core_valid,
  input  logic [DIGEST_W-1:0] i_core_answer,
  output logic [DIGEST_W-1:0] o_digest,
  output logic                o_digest_valid,
  output logic                o_timeout
);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = (WW > 4) ? WW : 4;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(NUM_BYTES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BCNT_W-1:0] byte_q, byte_d;
  logic vprev_q, ready_q, core_rst_n_q, dv_q, to_q;
  logic [7:0] text_q, msb;
  logic [DIGEST_W-1:0] digest_q;
  logic edge_w, to_hit, dv_d, to_d;
  assign edge_w = i_core_valid & ~vprev_q;
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign dv_d = (state_q == S_WAIT) && edge_w;
  assign to_d = (state_q == S_WAIT) && !edge_w && to_hit;
  hash160_block_shreg u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == S_IDLE && i_start),
    .shift_i(state_d == S_DATA),
    .data_i (i_block),
    .msb_o  (msb)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    byte_d = (state_q == S_DATA) ? byte_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: state_d = i_start ? S_CRST : S_IDLE;
      S_CRST: state_d = S_GAP;
      S_GAP: begin
        cnt_d = (cnt_q == GAP_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == GAP_LAST) ? S_HDR : S_GAP;
      end
      S_HDR: state_d = S_DATA;
      S_DATA: state_d = (byte_q == BYTE_LAST) ? S_WAIT : S_DATA;
      S_WAIT: begin
        cnt_d = (edge_w || to_hit) ? '0 : cnt_q + 1'b1;
        state_d = (edge_w || to_hit) ? S_IDLE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      byte_q <= '0;
      vprev_q <= 1'b1;
      ready_q <= 1'b1;
      core_rst_n_q <= 1'b1;
      text_q <= '0;
      digest_q <= '0;
      dv_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      vprev_q <= i_core_valid;
      ready_q <= state_d == S_IDLE;
      core_rst_n_q <= state_d != S_CRST;
      text_q <= (state_d == S_HDR) ? START_BYTE : (state_d == S_DATA) ? msb : 8'h00;
      dv_q <= dv_d;
      to_q <= to_d;
      if (dv_d) digest_q <= i_core_answer;
    end
  end
  assign o_ready = ready_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_text = text_q;
  assign o_digest = digest_q;
  assign o_digest_valid = dv_q;
  assign o_timeout = to_q;
endmodule

// File: tb/tb_hash160_frame_tx.sv
// tb_hash160_frame_tx: random frames checked cycle by cycle against an offset-based frame model
module tb_hash160_frame_tx;
  localparam int G = 2;
  localparam int T = 50;
  logic clk = 0, rst = 1, i_start = 0, i_core_valid = 0;
  logic [511:0] i_block = '0;
  logic [159:0] i_core_answer = '0;
  logic o_ready, o_core_rst_n, o_digest_valid, o_timeout;
  logic [7:0] o_text;
  logic [159:0] o_digest;
  logic [159:0] exp_digest = '0;
  int total = 0, bad = 0;

  hash160_frame_tx #(.GAP_CYCLES(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_block(i_block), .o_ready(o_ready),
    .o_core_rst_n(o_core_rst_n), .o_text(o_text), .i_core_valid(i_core_valid),
    .i_core_answer(i_core_answer), .o_digest(o_digest), .o_digest_valid(o_digest_valid),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom)};
    return b;
  endfunction

  function automatic logic [511:0] count_block();
    logic [511:0] b = '0;
    for (int j = 0; j < 64; j++) b[511-8*j -: 8] = 8'(j);
    return b;
  endfunction

  // Frame timeline as offsets from the accepting edge: 1 core reset, G gap, header,
  // 64 data bytes, then wait. L>0: valid rises in wait cycle L; L=0: no edge, timeout.
  task automatic run_frame(input logic [511:0] blk, input int L, input bit hold, input bit hi, input bit glitch);
    int ws = 67 + G;
    int endo = ws + ((L != 0) ? L : T);
    logic [159:0] ans = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    logic [7:0] et;
    i_block = blk;
    i_start = 1;
    i_core_answer = ans;
    if (hi) i_core_valid = 1;
    @(posedge clk);
    #1;
    if (!hold) i_start = 0;
    i_block = rand_block();
    for (int off = 1; off <= endo; off++) begin
      i_core_valid = hi | (L != 0 && off >= ws - 1 + L) | (glitch && off == 30);
      @(negedge clk);
      et = (off == 2 + G) ? 8'hAA :
           (off >= 3 + G && off <= 66 + G) ? blk[511-8*(off-3-G) -: 8] : 8'h00;
      if (off == endo && L != 0) exp_digest = ans;
      check($sformatf("text@%0d", off), o_text, et);
      check($sformatf("core_rst_n@%0d", off), o_core_rst_n, off != 1);
      check($sformatf("ready@%0d", off), o_ready, off == endo);
      check($sformatf("digest_valid@%0d", off), o_digest_valid, off == endo && L != 0);
      check($sformatf("timeout@%0d", off), o_timeout, off == endo && L == 0);
      check($sformatf("digest@%0d", off), o_digest, exp_digest);
      if (off < endo) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic rst_mid_frame();
    i_core_valid = 0;
    i_block = count_block();
    i_start = 1;
    @(posedge clk);
    #1;
    i_start = 0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("pre_rst_byte10", o_text, 8'd10);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_digest = '0;
    @(negedge clk);
    check("rst_text", o_text, 8'h00);
    check("rst_core_rst_n", o_core_rst_n, 1'b1);
    check("rst_ready", o_ready, 1'b1);
    check("rst_digest", o_digest, exp_digest);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", o_ready, 1'b1);
    check("reset_core_rst_n", o_core_rst_n, 1'b1);
    check("reset_text", o_text, 8'h00);
    check("reset_digest", o_digest, '0);
    check("reset_digest_valid", o_digest_valid, 1'b0);
    check("reset_timeout", o_timeout, 1'b0);
    rst = 0;
    run_frame(count_block(), 40, 0, 0, 0);
    run_frame(rand_block(), int'($urandom_range(1, T)), 1, 0, 0);
    run_frame(rand_block(), 25, 0, 0, 0);
    run_frame(rand_block(), 0, 0, 1, 0);
    run_frame(rand_block(), T, 0, 0, 0);
    run_frame(rand_block(), 1, 0, 0, 1);
    rst_mid_frame();
    run_frame(count_block(), 40, 0, 0, 0);
    repeat (20)
      run_frame(rand_block(), int'($urandom_range(1, T)), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash160_frame_tx.md
# hash160_frame_tx

Transmit-side framer for the Hash160 core's byte-serial input. It accepts one 512-bit pre-padded message block and drives the core's 8-bit `i_text` stream: a core reset pulse, idle gap, start byte, then 64 data bytes. It then waits for the core's `o_valid` rising edge, captures the 160-bit answer and reports it with a one-cycle strobe. It sits between the system/CPU side and the `top` Hash160 core; it is the counterpart of the core's input receiver.

## Interface
- `START_BYTE`, 8'hAA: frame start marker.
- `GAP_CYCLES`, 2: cycles of 0x00 between core reset release and the start byte; legal range 1..15.
- `NUM_BYTES`, 64: data bytes per frame.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request to send `i_block`; accepted only when `o_ready`=1.
- `i_block`  in  512  message block; byte j = `i_block[511-8j -: 8]`, byte 0 is sent first.
- `o_ready`  out  1  high in IDLE only.
- `o_core_rst_n`  out  1  drives the core's `rst_n`; active-low.
- `o_text`  out  8  drives the core's `i_text`.
- `i_core_valid`  in  1  the core's `o_valid`.
- `i_core_answer`  in  160  the core's `o_answer`.
- `o_digest`  out  160  last captured answer.
- `o_digest_valid`  out  1  one-cycle strobe when `o_digest` updates.
- `o_timeout`  out  1  one-cycle strobe when WAIT expires.

## Operation
- States: IDLE → CRST → GAP → HDR → DATA → WAIT → IDLE.
- IDLE:
  - `o_text`=0, `o_ready`=1.
  - `i_start`=1 latches `i_block` into a 512-bit shift register and moves to CRST.
- CRST: one cycle; `o_core_rst_n`=0, `o_text`=0. All other states hold `o_core_rst_n`=1.
- GAP: `GAP_CYCLES` cycles; `o_text`=0.
- HDR: one cycle; `o_text`=`START_BYTE`.
- DATA:
  - `NUM_BYTES` cycles; `o_text`=`shreg[511:504]`; the register shifts left 8 bits per cycle.
  - A 6-bit byte counter leaves DATA after byte 63.
- WAIT:
  - `o_text`=0.
  - A rising edge on `i_core_valid` (current=1, previous registered sample=0) loads `o_digest`<=`i_core_answer`, pulses `o_digest_valid`, and returns to IDLE.
- Timeout: a WAIT counter that reaches `TIMEOUT` (when nonzero) pulses `o_timeout` and returns to IDLE. `o_digest` is unchanged.
- `i_core_valid` edges outside WAIT are ignored.
- The previous-valid register updates every cycle; its reset value is 1, so a valid that is already high cannot fake an edge.
- `i_start` outside IDLE is ignored. `i_block` changes after acceptance have no effect.
- If a valid edge and a timeout occur in the same cycle, the digest wins: no `o_timeout` pulse.

## Timing
- Reset values: state=IDLE, `o_ready`=1, `o_core_rst_n`=1, `o_text`=0, `o_digest`=0, `o_digest_valid`=0, `o_timeout`=0, shreg=0, counters=0.
- `rst` mid-frame: IDLE on the next edge and `o_text`=0. The core sees a truncated frame; this block does not retry.
- `i_start` sampled at edge k, with default `GAP_CYCLES`=2:
  - CRST during cycle k+1.
  - GAP during cycles k+2..k+3.
  - 0xAA during cycle k+4.
  - Data bytes 0..63 during cycles k+5..k+68.
  - WAIT from k+69.
- All outputs are registered; no combinational input-to-output path.
- `o_digest_valid` is high in the cycle after the sampled valid edge; `o_ready` rises in the same cycle.
- Back-to-back frames: a new `i_start` is accepted in the first IDLE cycle.

## Structure
- `hash160_pkg` holds:
  - the state enum;
  - `START_BYTE`;
  - `NUM_BYTES`;
  - `BLOCK_W`=512 and `DIGEST_W`=160;
  - the byte-counter width.
- One natural sub-module: `hash160_block_shreg`, a 512-bit load / shift-by-8 register with an MSB-byte output.
- Top-level content is the FSM, the counters and the edge detect; target about 200 lines total.

## Test plan
- Reset, then `i_block`=512'h0011..3F (byte j = j), `i_start` pulse:
  - `o_core_rst_n` low for exactly 1 cycle;
  - `o_text` = 00,00,AA,00,01,…,3F at cycles k+2..k+68.
- Loop back into a core model that raises valid 40 cycles after byte 63 with answer 160'h1234…:
  - `o_digest` equals it;
  - `o_digest_valid` is a 1-cycle pulse;
  - `o_ready`=1 on the same cycle.
- `i_start` held high through an entire frame: exactly one frame is emitted, and a second starts in the first IDLE cycle.
- `i_core_valid` held high before and during WAIT with no edge, `TIMEOUT`=20: `o_timeout` pulses at WAIT cycle 20, and `o_digest` is unchanged.
- `rst` asserted at data byte 10: next cycle `o_text`=0, `o_core_rst_n`=1, `o_ready`=1; a subsequent frame is bit-exact.
- 100 random blocks against golden Hash160 vectors through a real `top` instance: all digests match.
